instruction_fetch: RTL

Fetch stage of the RockWave core: holds the program counter, reads one 32-bit instruction per fetch phase from instruction memory over a req/ack handshake, and presents `inst`, `curr_pc_fd` and `next_pc_fd` to `instruction_decode`. It is the producer side of the decode interface. It also accepts PC redirects from the execute stage for jumps and branches.

---
 rtl/instruction_fetch_pkg.sv | 13 +
 rtl/instruction_fetch_obuf.sv | 35 +++
 rtl/instruction_fetch.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM encoding and output bundle type for the RockWave fetch stage.
package instruction_fetch_pkg;

    localparam int              XLEN_DEF         = 32;
    localparam logic [31:0]     NOP_INST         = 32'h0000_0013;
    localparam logic [31:0]     RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_obuf.sv
// Output buffer for the fetch/decode interface: holds inst and its PCs until the next capture.
module instruction_fetch_obuf
    import instruction_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [31:0]     inst_d,
    input  logic [XLEN-1:0] curr_pc_d,
    input  logic [XLEN-1:0] next_pc_d,
    output logic [31:0]     inst_q,
    output logic [XLEN-1:0] curr_pc_q,
    output logic [XLEN-1:0] next_pc_q
);

    // Capture register; holds between enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= NOP_INST;
            curr_pc_q <= {XLEN{1'b0}};
            next_pc_q <= {XLEN{1'b0}};
        end else if (en) begin
            inst_q    <= inst_d;
            curr_pc_q <= curr_pc_d;
            next_pc_q <= next_pc_d;
        end else begin
            inst_q    <= inst_q;
            curr_pc_q <= curr_pc_q;
            next_pc_q <= next_pc_q;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// RockWave fetch stage: PC, req/ack instruction read, execute redirects.
// Optional MISALIGN_CHECK_EN flags misaligned redirect targets instead of masking them.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            phase_fetch,
    input  logic            jump_en_ex,
    input  logic [XLEN-1:0] jump_addr_ex,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] curr_pc_fd,
    output logic [XLEN-1:0] next_pc_fd,
    output logic            fetch_valid,
    output logic            stall_fetch,
    output logic            misalign_fd
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    fetch_state_e    state_r,      state_nxt_s;
    logic [XLEN-1:0] pc_r,         pc_nxt_s;
    logic [XLEN-1:0] imem_addr_r,  imem_addr_nxt_s;
    logic            redir_pend_r, redir_pend_nxt_s;
    logic [XLEN-1:0] redir_addr_r, redir_addr_nxt_s;
    logic            fetch_valid_r, fetch_valid_nxt_s;
    logic            misalign_r,   misalign_nxt_s;

    logic [XLEN-1:0] jump_tgt_s;
    logic [XLEN-1:0] fetch_addr_s;
    logic            fetch_mis_s;
    logic            cap_en_s;
    logic [31:0]     cap_inst_s;
    logic [XLEN-1:0] cap_pc_s;
    logic [XLEN-1:0] cap_next_pc_s;

`ifdef MISALIGN_CHECK_EN
    // Targets keep their low bits so a bad redirect can be reported downstream.
    assign jump_tgt_s  = jump_addr_ex;
    assign fetch_mis_s = (fetch_addr_s[1:0] != 2'b00);
`else
    assign jump_tgt_s  = jump_addr_ex & {{(XLEN-2){1'b1}}, 2'b00};
    assign fetch_mis_s = 1'b0;
`endif

    assign fetch_addr_s  = jump_en_ex ? jump_tgt_s : pc_r;
    assign cap_next_pc_s = cap_pc_s + PC_STEP;

    // Next-state, redirect bookkeeping and capture control.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        imem_addr_nxt_s   = imem_addr_r;
        redir_pend_nxt_s  = redir_pend_r;
        redir_addr_nxt_s  = redir_addr_r;
        fetch_valid_nxt_s = 1'b0;
        misalign_nxt_s    = misalign_r;
        cap_en_s          = 1'b0;
        cap_inst_s        = imem_rdata;
        cap_pc_s          = imem_addr_r;

        case (state_r)
            ST_IDLE: begin
                if (phase_fetch) begin
                    pc_nxt_s = fetch_addr_s;
                    if (fetch_mis_s) begin
                        // Bad target: report it as a NOP without touching memory.
                        cap_en_s          = 1'b1;
                        cap_inst_s        = NOP_INST;
                        cap_pc_s          = fetch_addr_s;
                        fetch_valid_nxt_s = 1'b1;
                        misalign_nxt_s    = 1'b1;
                    end else begin
                        imem_addr_nxt_s = fetch_addr_s;
                        state_nxt_s     = ST_WAIT;
                    end
                end else if (jump_en_ex) begin
                    pc_nxt_s = jump_tgt_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_WAIT: begin
                if (jump_en_ex) begin
                    redir_pend_nxt_s = 1'b1;
                    redir_addr_nxt_s = jump_tgt_s;
                end else begin
                    redir_addr_nxt_s = redir_addr_r;
                end
                if (imem_ack) begin
                    cap_en_s          = 1'b1;
                    fetch_valid_nxt_s = 1'b1;
                    misalign_nxt_s    = 1'b0;
                    redir_pend_nxt_s  = 1'b0;
                    state_nxt_s       = ST_IDLE;
                    // A redirect arriving with the ack is the newest and wins.
                    if (jump_en_ex) begin
                        pc_nxt_s = jump_tgt_s;
                    end else if (redir_pend_r) begin
                        pc_nxt_s = redir_addr_r;
                    end else begin
                        pc_nxt_s = imem_addr_r + PC_STEP;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Architectural state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_VECTOR;
            imem_addr_r   <= {XLEN{1'b0}};
            redir_pend_r  <= 1'b0;
            redir_addr_r  <= {XLEN{1'b0}};
            fetch_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            imem_addr_r   <= imem_addr_nxt_s;
            redir_pend_r  <= redir_pend_nxt_s;
            redir_addr_r  <= redir_addr_nxt_s;
            fetch_valid_r <= fetch_valid_nxt_s;
            misalign_r    <= misalign_nxt_s;
        end
    end

    instruction_fetch_obuf #(
        .XLEN (XLEN)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cap_en_s),
        .inst_d    (cap_inst_s),
        .curr_pc_d (cap_pc_s),
        .next_pc_d (cap_next_pc_s),
        .inst_q    (inst),
        .curr_pc_q (curr_pc_fd),
        .next_pc_q (next_pc_fd)
    );

    assign imem_req    = (state_r == ST_WAIT);
    assign stall_fetch = (state_r == ST_WAIT);
    assign imem_addr   = imem_addr_r;
    assign fetch_valid = fetch_valid_r;
    assign misalign_fd = misalign_r;

endmodule
